// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared state encoding and defaults for the early-response debouncer
package debounce_pkg;

    // ZERO/ONE are the settled levels, WAIT1/WAIT0 the blanking windows after an edge
    typedef enum logic [1:0] {
        ZERO  = 2'd0,
        WAIT1 = 2'd1,
        ONE   = 2'd2,
        WAIT0 = 2'd3
    } state_t;

    localparam int N_WAIT_DEF      = 3;
    localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/sync_ff.sv
// rtl/sync_ff.sv - multi-flop level synchronizer, cleared to 0 on reset
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Shift the asynchronous level through the chain; only the last flop is used downstream
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/early_debounce_fsm.sv
// rtl/early_debounce_fsm.sv - early-response switch debouncer with tick-timed blanking window
module early_debounce_fsm
    import debounce_pkg::*;
#(
    parameter int N_WAIT      = N_WAIT_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic sw,
    output logic db,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam int            CW   = $clog2(N_WAIT + 1);
    localparam logic [CW-1:0] LAST = CW'(N_WAIT - 1);

    logic          sw_s;
    state_t        state;
    logic [CW-1:0] cnt;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (sw),
        .q     (sw_s)
    );

    // State, window counter and all outputs move together so every output is a flop.
    // db changes on entry to a window (early response), and the window then blanks sw_s
    // until N_WAIT ticks have been counted. A tick coinciding with window entry is dropped
    // because the counter is being cleared in that same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ZERO;
            cnt   <= '0;
            db    <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            case (state)
                ZERO: begin
                    if (sw_s) begin
                        state <= WAIT1;
                        cnt   <= '0;
                        db    <= 1'b1;
                        rise  <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                WAIT1: begin
                    if (tick) begin
                        if (cnt == LAST) begin
                            state <= ONE;
                            cnt   <= '0;
                            busy  <= 1'b0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                ONE: begin
                    if (!sw_s) begin
                        state <= WAIT0;
                        cnt   <= '0;
                        db    <= 1'b0;
                        fall  <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                WAIT0: begin
                    if (tick) begin
                        if (cnt == LAST) begin
                            state <= ZERO;
                            cnt   <= '0;
                            busy  <= 1'b0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                default: begin
                    state <= ZERO;
                    cnt   <= '0;
                    db    <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_early_debounce_fsm.sv
// tb/tb_early_debounce_fsm.sv - directed vector bench for early_debounce_fsm
module tb_early_debounce_fsm;

    logic clk = 1'b0;
    logic reset;
    logic tick;
    logic sw;
    logic db;
    logic rise;
    logic fall;
    logic busy;

    int n_cmp  = 0;
    int n_fail = 0;
    int tcnt   = 0;
    bit tick_en = 1'b0;

    typedef struct {
        logic       sw;
        logic       tick;
        logic [3:0] exp;
    } vec_t;

    vec_t tbl [17];

    early_debounce_fsm #(
        .N_WAIT      (3),
        .SYNC_STAGES (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .tick  (tick),
        .sw    (sw),
        .db    (db),
        .rise  (rise),
        .fall  (fall),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] outs();
        return {db, rise, fall, busy};
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: db/rise/fall/busy got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic raw_step(input logic sw_v, input logic tick_v);
        sw   = sw_v;
        tick = tick_v;
        @(posedge clk);
        #1;
    endtask

    // tick every 10th step (steps 10, 20, 30, ... after the last do_reset)
    task automatic step(input logic sw_v);
        sw   = sw_v;
        tick = tick_en && (tcnt == 9);
        tcnt = (tcnt == 9) ? 0 : tcnt + 1;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        sw    = 1'b0;
        tick  = 1'b0;
        tcnt  = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   rises;
        int   bad;
        logic swv;

        // sw, tick, expected {db,rise,fall,busy} after each edge
        tbl[0]  = '{1'b1, 1'b0, 4'b0000};
        tbl[1]  = '{1'b1, 1'b0, 4'b0000};
        tbl[2]  = '{1'b1, 1'b1, 4'b1101};
        tbl[3]  = '{1'b0, 1'b0, 4'b1001};
        tbl[4]  = '{1'b1, 1'b1, 4'b1001};
        tbl[5]  = '{1'b1, 1'b0, 4'b1001};
        tbl[6]  = '{1'b1, 1'b1, 4'b1001};
        tbl[7]  = '{1'b1, 1'b0, 4'b1001};
        tbl[8]  = '{1'b1, 1'b1, 4'b1000};
        tbl[9]  = '{1'b1, 1'b0, 4'b1000};
        tbl[10] = '{1'b0, 1'b0, 4'b1000};
        tbl[11] = '{1'b0, 1'b0, 4'b1000};
        tbl[12] = '{1'b0, 1'b0, 4'b0011};
        tbl[13] = '{1'b0, 1'b1, 4'b0001};
        tbl[14] = '{1'b0, 1'b1, 4'b0001};
        tbl[15] = '{1'b0, 1'b1, 4'b0000};
        tbl[16] = '{1'b0, 1'b0, 4'b0000};

        do_reset();
        check("reset_state", outs(), 4'b0000);

        for (int i = 0; i < 17; i++) begin
            raw_step(tbl[i].sw, tbl[i].tick);
            check($sformatf("vec[%0d]", i), outs(), tbl[i].exp);
        end

        // clean press, tick every 10 cycles: window opens at step 3, closes on tick at step 30
        do_reset();
        tick_en = 1'b1;
        for (int k = 1; k <= 31; k++) begin
            step(1'b1);
            if (k == 2)  check("press_k2", outs(), 4'b0000);
            if (k == 3)  check("press_rise", outs(), 4'b1101);
            if (k == 4)  check("press_k4", outs(), 4'b1001);
            if (k == 29) check("press_k29", outs(), 4'b1001);
            if (k == 30) check("press_expire", outs(), 4'b1000);
            if (k == 31) check("press_k31", outs(), 4'b1000);
        end

        // bounce for 15 cycles after the press
        do_reset();
        tick_en = 1'b1;
        rises = 0;
        bad   = 0;
        for (int k = 1; k <= 45; k++) begin
            swv = (k <= 15) ? ((((k - 1) / 2) % 2) == 0) : 1'b1;
            step(swv);
            if (rise) rises++;
            if (k >= 3 && db !== 1'b1) bad++;
        end
        check_int("bounce_rise_count", rises, 1);
        check_int("bounce_db_low_cycles", bad, 0);
        check("bounce_final", outs(), 4'b1000);

        // release during the window: settle in ONE, then fall on the next cycle
        do_reset();
        tick_en = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            step(k <= 5);
            if (k == 29) check("release_k29", outs(), 4'b1001);
            if (k == 30) check("release_expire_one", outs(), 4'b1000);
            if (k == 31) check("release_fall", outs(), 4'b0011);
            if (k == 32) check("release_k32", outs(), 4'b0001);
        end

        // reset in WAIT1 with count 1
        do_reset();
        tick_en = 1'b1;
        for (int k = 1; k <= 12; k++) step(1'b1);
        check("midwin_before", outs(), 4'b1001);
        #2;
        reset = 1'b1;
        #1;
        check("midwin_async_clear", outs(), 4'b0000);
        @(posedge clk);
        #1;
        check("midwin_held", outs(), 4'b0000);
        reset   = 1'b0;
        tick_en = 1'b0;
        tcnt    = 0;
        step(1'b1);
        step(1'b1);
        check("midwin_post_k2", outs(), 4'b0000);
        step(1'b1);
        check("midwin_post_rise", outs(), 4'b1101);

        // no tick: window never closes
        do_reset();
        tick_en = 1'b0;
        bad = 0;
        for (int k = 1; k <= 200; k++) begin
            step(1'b1);
            if (k >= 3 && (busy !== 1'b1 || db !== 1'b1)) bad++;
        end
        check_int("notick_not_busy_cycles", bad, 0);
        check("notick_final", outs(), 4'b1001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
